sd_sector_feeder: RTL and testbench
===================================

SD_SECTOR_FEEDER -- requirements
Module: sd_sector_feeder

Interface
REQ-001 Parameter PAD_BYTE, default 8'h00: fill value used to complete a partial sector on flush.
REQ-002 Parameter TIMEOUT_CYCLES, default 32'd50_000_000: clk cycles allowed per sector write before a timeout is declared.
REQ-003 clk  input  1  sole clock; all logic samples on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream byte valid.
REQ-006 in_data  input  8  upstream byte.
REQ-007 in_ready  output  1  byte accepted on the cycle in_valid & in_ready.
REQ-008 flush  input  1  single-cycle request to close the current partial sector.
REQ-009 base_load  input  1  load base_sector into the next-sector register.
REQ-010 base_sector  input  32  starting sector number, in sector units.
REQ-011 isAbleToLaunch  input  1  writer idle and ready for StartWrite.
REQ-012 StartWrite  output  1  request to write one sector.
REQ-013 writeSectorAddress  output  32  sector number for the current write.
REQ-014 inByte  output  8  byte presented to the writer.
REQ-015 prepareNextByte  input  1  writer-latched-byte indication; each rising edge consumes one byte.
REQ-016 writeBlockFinish  input  1  writer sector-complete indication; its rising edge is significant.
REQ-017 sectors_written  output  32  count of completed sectors.
REQ-018 write_error  output  1  sticky error flag.
REQ-019 feeder_busy  output  1  high when any bank is full or a write is in progress.

Function
REQ-020 Two 512x8 banks (A, B) SHALL operate as a ping-pong buffer: one bank fills while the other drains.
- Each bank carries a full flag.
- The fill bank and the drain bank SHALL alternate, starting with A.
REQ-021 Fill side:
- in_ready = ~full[fill_bank] & ~padding.
- An accepted byte SHALL be stored at fill_cnt, and fill_cnt SHALL increment.
- At fill_cnt = 511 accepted, the bank SHALL be marked full, fill_cnt SHALL clear to 0, and fill_bank SHALL toggle.
REQ-022 Flush:
- With fill_cnt > 0, flush SHALL set padding.
- While padding, PAD_BYTE SHALL be written at one byte per clk until the bank completes, then padding SHALL clear.
- With fill_cnt = 0, flush SHALL be ignored.
- A flush asserted while padding SHALL be ignored.
REQ-023 Drain FSM states: IDLE, LAUNCH, SEND, DONE.
REQ-024 IDLE: full[drain_bank] SHALL cause a transition to LAUNCH with rd_ptr = 0.
REQ-025 LAUNCH:
- StartWrite = isAbleToLaunch.
- writeSectorAddress SHALL hold next_sector.
- A 1->0 transition of isAbleToLaunch, observed after StartWrite was asserted, SHALL cause a transition to SEND and drop StartWrite.
REQ-026 SEND byte serving:
- inByte SHALL be registered from bank[drain_bank][rd_ptr], with 1 clk latency after any rd_ptr change.
- Each prepareNextByte rising edge (0 in the previous clk, 1 now) SHALL increment rd_ptr, saturating at 512.
- Rising edges beyond 512 SHALL be ignored.
REQ-027 SEND completion:
- A rising edge of writeBlockFinish SHALL cause a transition to DONE.
- If rd_ptr < 512 at that edge, write_error SHALL be set; the sector SHALL still be retired.
REQ-028 DONE, lasting exactly 1 clk:
- clear full[drain_bank];
- toggle drain_bank;
- next_sector += 1 (mod 2^32);
- sectors_written += 1 (mod 2^32);
- transition to IDLE.
REQ-029 Timeout:
- The cycle counter SHALL clear on entry to LAUNCH.
- The counter reaching TIMEOUT_CYCLES in LAUNCH or SEND SHALL set write_error and re-enter LAUNCH with the same bank and address, with rd_ptr = 0.
REQ-030 base_load SHALL update next_sector only while the FSM is IDLE and neither bank is full; otherwise it SHALL be ignored.
REQ-031 Simultaneous events:
- A fill completing in the same clk as DONE clears that bank SHALL be legal; both updates SHALL apply.
- in_ready SHALL reflect full flags registered at the start of the clk.
REQ-032 feeder_busy = (state != IDLE) | full[A] | full[B].

Reset
REQ-033 On rst = 1 at a clk edge, the following SHALL be set:
- outputs: StartWrite = 0, inByte = 0, sectors_written = 0, write_error = 0, writeSectorAddress = 0, in_ready = 1 from the next clk;
- internal state: state = IDLE, both full flags = 0, fill_bank = drain_bank = A, fill_cnt = 0, rd_ptr = 0, padding = 0, next_sector = 0, edge-detect registers = 0.
REQ-034 Reset mid-write SHALL discard both banks, and SHALL NOT retry after reset.
REQ-035 Bank RAM contents need no reset.

Verification
REQ-036 base_load with base_sector = 100; stream 512 bytes 0..255,0..255 -> StartWrite with writeSectorAddress = 100; writer model reads 512 bytes matching the stream; sectors_written = 1.
REQ-037 Stream 1024 bytes with the writer stalled -> both banks full, in_ready = 0, no byte lost; after two writes, addresses = 100 and 101 and in_ready = 1.
REQ-038 Write 10 bytes then flush -> 502 PAD_BYTE appended, in_ready = 0 during padding; the sector written contains 10 data bytes followed by 502 PAD_BYTE.
REQ-039 Writer never drops isAbleToLaunch, TIMEOUT_CYCLES = 1000 -> write_error = 1 at cycle 1000; StartWrite reasserted with the same address.
REQ-040 writeBlockFinish after 300 prepareNextByte edges -> write_error = 1; sector retired; next_sector incremented.
REQ-041 rst asserted during SEND at byte 200 -> next clk: state IDLE, StartWrite = 0, sectors_written = 0, in_ready = 1.

Source files
------------

// File: rtl/sd_sector_feeder.sv
// sd_sector_feeder
//   Buffers an upstream byte stream into 512-byte sectors and hands each sector
//   to an SD sector writer. Two 512x8 banks (A, B) form a ping-pong buffer: one
//   bank fills from the byte stream while the other drains to the writer.
//
//   Ports
//     clk, rst              clock, synchronous active-high reset
//     in_valid/in_data      upstream byte stream
//     in_ready              byte accepted when in_valid & in_ready
//     flush                 close the current partial sector (PAD_BYTE fill)
//     base_load/base_sector load the starting sector number
//     isAbleToLaunch        writer idle and ready for StartWrite
//     StartWrite            request to write one sector
//     writeSectorAddress    sector number of the current write
//     inByte                byte presented to the writer
//     prepareNextByte       rising edge = writer consumed inByte
//     writeBlockFinish      rising edge = writer finished the sector
//     sectors_written       count of retired sectors
//     write_error           sticky error (short sector or timeout)
//     feeder_busy           a bank is full or a write is in progress
module sd_sector_feeder #(
   parameter logic [7:0]  PAD_BYTE       = 8'h00,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   input  logic        flush,
   input  logic        base_load,
   input  logic [31:0] base_sector,
   input  logic        isAbleToLaunch,
   output logic        StartWrite,
   output logic [31:0] writeSectorAddress,
   output logic [7:0]  inByte,
   input  logic        prepareNextByte,
   input  logic        writeBlockFinish,
   output logic [31:0] sectors_written,
   output logic        write_error,
   output logic        feeder_busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_SEND   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Both banks in one array: address = {bank, byte index}.
   logic [7:0]  mem_r [0:1023];

   state_t      state_r;
   logic [1:0]  full_r;
   logic        fill_bank_r;
   logic        drain_bank_r;
   logic        padding_r;
   logic [8:0]  fill_cnt_r;
   logic [9:0]  rd_ptr_r;
   logic [31:0] next_sector_r;
   logic [31:0] tmo_cnt_r;
   logic        pnb_q_r;
   logic        wbf_q_r;
   logic        start_write_r;
   logic [31:0] write_addr_r;
   logic [7:0]  in_byte_r;
   logic [31:0] sectors_written_r;
   logic        write_error_r;

   logic        in_ready_s;
   logic        wr_en_s;
   logic [7:0]  wr_data_s;
   logic        fill_last_s;
   logic        pnb_rise_s;
   logic        wbf_rise_s;
   logic        tmo_hit_s;
   logic        done_s;

   // Fill-side handshake, writer edge detection and timeout decode.
   always_comb begin
      in_ready_s  = ~full_r[fill_bank_r] & ~padding_r;
      // Padding takes the write port instead of the upstream stream.
      wr_en_s     = (in_valid & in_ready_s) | padding_r;
      wr_data_s   = padding_r ? PAD_BYTE : in_data;
      fill_last_s = wr_en_s & (fill_cnt_r == 9'd511);
      pnb_rise_s  = prepareNextByte & ~pnb_q_r;
      wbf_rise_s  = writeBlockFinish & ~wbf_q_r;
      tmo_hit_s   = ((tmo_cnt_r + 32'd1) == TIMEOUT_CYCLES);
      done_s      = (state_r == ST_DONE);
   end

   // Bank RAM write port; contents are never reset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[{fill_bank_r, fill_cnt_r}] <= wr_data_s;
      end
   end

   // Fill side: byte counter, bank switch, flush padding and full flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         full_r      <= 2'b00;
         fill_bank_r <= 1'b0;
         fill_cnt_r  <= 9'd0;
         padding_r   <= 1'b0;
      end else begin
         if (wr_en_s) begin
            if (fill_last_s) begin
               full_r[fill_bank_r] <= 1'b1;
               fill_cnt_r          <= 9'd0;
               fill_bank_r         <= ~fill_bank_r;
               padding_r           <= 1'b0;
            end else begin
               fill_cnt_r <= fill_cnt_r + 9'd1;
            end
         end
         // A flush on the cycle that completes the sector has nothing left to pad.
         if (flush && !padding_r && (fill_cnt_r != 9'd0) && !fill_last_s) begin
            padding_r <= 1'b1;
         end
         // Drain bank always differs from a bank completing its fill here.
         if (done_s) begin
            full_r[drain_bank_r] <= 1'b0;
         end
      end
   end

   // Drain FSM: launch, byte serving, completion, timeout retry and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r           <= ST_IDLE;
         drain_bank_r      <= 1'b0;
         rd_ptr_r          <= 10'd0;
         next_sector_r     <= 32'd0;
         tmo_cnt_r         <= 32'd0;
         pnb_q_r           <= 1'b0;
         wbf_q_r           <= 1'b0;
         start_write_r     <= 1'b0;
         write_addr_r      <= 32'd0;
         in_byte_r         <= 8'd0;
         sectors_written_r <= 32'd0;
         write_error_r     <= 1'b0;
      end else begin
         pnb_q_r <= prepareNextByte;
         wbf_q_r <= writeBlockFinish;
         if (base_load && (state_r == ST_IDLE) && (full_r == 2'b00)) begin
            next_sector_r <= base_sector;
         end
         case (state_r)
            ST_IDLE: begin
               start_write_r <= 1'b0;
               if (full_r[drain_bank_r]) begin
                  state_r      <= ST_LAUNCH;
                  rd_ptr_r     <= 10'd0;
                  tmo_cnt_r    <= 32'd0;
                  write_addr_r <= next_sector_r;
               end
            end
            ST_LAUNCH: begin
               in_byte_r <= mem_r[{drain_bank_r, rd_ptr_r[8:0]}];
               if (tmo_hit_s) begin
                  // Retry the same bank/address; StartWrite drops for one clk.
                  write_error_r <= 1'b1;
                  start_write_r <= 1'b0;
                  tmo_cnt_r     <= 32'd0;
                  rd_ptr_r      <= 10'd0;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + 32'd1;
                  // Writer took the request once it drops isAbleToLaunch.
                  if (start_write_r && !isAbleToLaunch) begin
                     state_r       <= ST_SEND;
                     start_write_r <= 1'b0;
                  end else begin
                     start_write_r <= isAbleToLaunch;
                  end
               end
            end
            ST_SEND: begin
               in_byte_r <= mem_r[{drain_bank_r, rd_ptr_r[8:0]}];
               if (tmo_hit_s) begin
                  write_error_r <= 1'b1;
                  start_write_r <= 1'b0;
                  tmo_cnt_r     <= 32'd0;
                  rd_ptr_r      <= 10'd0;
                  state_r       <= ST_LAUNCH;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + 32'd1;
                  if (pnb_rise_s && (rd_ptr_r != 10'd512)) begin
                     rd_ptr_r <= rd_ptr_r + 10'd1;
                  end
                  if (wbf_rise_s) begin
                     // A short sector is flagged but still retired.
                     if (rd_ptr_r < 10'd512) begin
                        write_error_r <= 1'b1;
                     end
                     state_r <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               drain_bank_r      <= ~drain_bank_r;
               next_sector_r     <= next_sector_r + 32'd1;
               sectors_written_r <= sectors_written_r + 32'd1;
               state_r           <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready           = in_ready_s;
   assign StartWrite         = start_write_r;
   assign writeSectorAddress = write_addr_r;
   assign inByte             = in_byte_r;
   assign sectors_written    = sectors_written_r;
   assign write_error        = write_error_r;
   assign feeder_busy        = (state_r != ST_IDLE) | full_r[0] | full_r[1];

endmodule

// File: tb/tb_sd_sector_feeder.sv
module tb_sd_sector_feeder;

   localparam logic [7:0] PAD = 8'hA5;

   logic        clk = 1'b0;
   logic        rst, rst_t;
   logic        in_valid, flush, base_load, ial, pnb, wbf;
   logic [7:0]  in_data;
   logic [31:0] base_sector;
   logic        in_ready, sw, werr, busy;
   logic [31:0] wsa, scnt;
   logic [7:0]  inbyte;
   logic        t_in_ready, t_sw, t_werr, t_busy;
   logic [31:0] t_wsa, t_scnt;
   logic [7:0]  t_inbyte;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   sd_sector_feeder #(.PAD_BYTE(PAD), .TIMEOUT_CYCLES(32'd20000)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .flush(flush), .base_load(base_load), .base_sector(base_sector),
      .isAbleToLaunch(ial), .StartWrite(sw), .writeSectorAddress(wsa), .inByte(inbyte),
      .prepareNextByte(pnb), .writeBlockFinish(wbf), .sectors_written(scnt),
      .write_error(werr), .feeder_busy(busy));

   // Second instance with a short timeout; the writer never drops isAbleToLaunch.
   sd_sector_feeder #(.TIMEOUT_CYCLES(32'd1000)) dut_t (
      .clk(clk), .rst(rst_t), .in_valid(in_valid), .in_data(in_data), .in_ready(t_in_ready),
      .flush(1'b0), .base_load(base_load), .base_sector(base_sector),
      .isAbleToLaunch(1'b1), .StartWrite(t_sw), .writeSectorAddress(t_wsa), .inByte(t_inbyte),
      .prepareNextByte(1'b0), .writeBlockFinish(1'b0), .sectors_written(t_scnt),
      .write_error(t_werr), .feeder_busy(t_busy));

   typedef struct {
      logic rst;
      logic iv;
      logic fl;
      logic bl;
      logic rdy;
      logic busy;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; base_load = 1'b0;
      pnb = 1'b0; wbf = 1'b0; ial = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic load_base(input logic [31:0] v);
      base_load = 1'b1; base_sector = v;
      @(negedge clk);
      base_load = 1'b0;
   endtask

   // Called at a negedge; each byte is accepted on the following posedge.
   task automatic stream(input int n, input int start, input bit sel);
      int guard;
      for (int i = 0; i < n; i++) begin
         guard = 0;
         in_valid = 1'b1;
         in_data = 8'(start + i);
         while (!(sel ? t_in_ready : in_ready) && guard < 5000) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 5000) begin
            total++; bad++;
            $display("FAIL stream ready wait: in_ready stuck 0 at byte %0d, expected 1", i);
            break;
         end
         if (!sel) exp_q.push_back(in_data);
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   // Writer model: take StartWrite, read n bytes via prepareNextByte edges,
   // then (if finish) pulse writeBlockFinish.
   task automatic serve(input logic [31:0] addr, input int n, input bit finish);
      int guard;
      int nbad;
      logic [7:0] e;
      guard = 0;
      ial = 1'b1;
      while (sw !== 1'b1 && guard < 4000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 4000) begin
         total++; bad++;
         $display("FAIL start_write wait: StartWrite stayed 0, expected 1");
         return;
      end
      chk("write address", wsa, addr);
      ial = 1'b0;
      @(negedge clk);
      nbad = 0;
      for (int i = 0; i < n; i++) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (inbyte !== e) nbad++;
         end else begin
            nbad++;
         end
         pnb = 1'b1;
         @(negedge clk);
         pnb = 1'b0;
         @(negedge clk);
      end
      chk("sector byte mismatches", 32'(nbad), 32'd0);
      if (finish) begin
         for (int i = n; i < 512; i++) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
         wbf = 1'b1;
         @(negedge clk);
         wbf = 1'b0;
         ial = 1'b1;
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1; rst_t = 1'b1; in_valid = 1'b0; in_data = 8'd0; flush = 1'b0;
      base_load = 1'b0; base_sector = 32'd0; ial = 1'b0; pnb = 1'b0; wbf = 1'b0;

      //              rst   iv    fl    bl    rdy   busy
      vecs[0] = '{rst:1'b1, iv:1'b1, fl:1'b0, bl:1'b0, rdy:1'b1, busy:1'b0};
      vecs[1] = '{rst:1'b0, iv:1'b0, fl:1'b1, bl:1'b0, rdy:1'b1, busy:1'b0}; // flush at count 0 ignored
      vecs[2] = '{rst:1'b0, iv:1'b0, fl:1'b0, bl:1'b1, rdy:1'b1, busy:1'b0};
      vecs[3] = '{rst:1'b0, iv:1'b1, fl:1'b0, bl:1'b0, rdy:1'b1, busy:1'b0};
      vecs[4] = '{rst:1'b0, iv:1'b0, fl:1'b1, bl:1'b0, rdy:1'b0, busy:1'b0}; // padding starts
      vecs[5] = '{rst:1'b0, iv:1'b1, fl:1'b1, bl:1'b0, rdy:1'b0, busy:1'b0}; // flush while padding
      vecs[6] = '{rst:1'b1, iv:1'b0, fl:1'b0, bl:1'b0, rdy:1'b1, busy:1'b0}; // reset clears padding
      vecs[7] = '{rst:1'b0, iv:1'b1, fl:1'b0, bl:1'b0, rdy:1'b1, busy:1'b0};

      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rst = vecs[i].rst; in_valid = vecs[i].iv; flush = vecs[i].fl;
         base_load = vecs[i].bl; base_sector = 32'd100; in_data = 8'(i);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
         chk($sformatf("vec%0d feeder_busy", i), 32'(busy), 32'(vecs[i].busy));
         chk($sformatf("vec%0d StartWrite", i), 32'(sw), 32'd0);
         chk($sformatf("vec%0d sectors_written", i), scnt, 32'd0);
         chk($sformatf("vec%0d write_error", i), 32'(werr), 32'd0);
         @(negedge clk);
      end
      in_valid = 1'b0; flush = 1'b0; base_load = 1'b0;

      // One full sector at base address 100.
      do_reset();
      load_base(32'd100);
      stream(512, 0, 1'b0);
      serve(32'd100, 512, 1'b1);
      chk("A sectors_written", scnt, 32'd1);
      chk("A write_error", 32'(werr), 32'd0);
      chk("A feeder_busy", 32'(busy), 32'd0);
      chk("A in_ready", 32'(in_ready), 32'd1);

      // Writer stalled: both banks fill, base_load ignored while full.
      do_reset();
      load_base(32'd100);
      ial = 1'b0;
      stream(1024, 37, 1'b0);
      chk("B in_ready both full", 32'(in_ready), 32'd0);
      chk("B feeder_busy", 32'(busy), 32'd1);
      load_base(32'd999);
      in_valid = 1'b1; in_data = 8'hEE;
      repeat (5) @(negedge clk);
      in_valid = 1'b0;
      chk("B in_ready still full", 32'(in_ready), 32'd0);
      serve(32'd100, 512, 1'b1);
      chk("B in_ready after first write", 32'(in_ready), 32'd1);
      serve(32'd101, 512, 1'b1);
      chk("B sectors_written", scnt, 32'd2);
      chk("B in_ready", 32'(in_ready), 32'd1);
      chk("B feeder_busy idle", 32'(busy), 32'd0);

      // 10 bytes then flush: 502 pad bytes, no upstream bytes taken meanwhile.
      do_reset();
      load_base(32'd200);
      stream(10, 8'h30, 1'b0);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("C in_ready padding start", 32'(in_ready), 32'd0);
      for (int i = 0; i < 502; i++) exp_q.push_back(PAD);
      in_valid = 1'b1; in_data = 8'h77;
      repeat (200) @(negedge clk);
      chk("C in_ready mid padding", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      repeat (320) @(negedge clk);
      chk("C in_ready after padding", 32'(in_ready), 32'd1);
      serve(32'd200, 512, 1'b1);
      chk("C sectors_written", scnt, 32'd1);
      chk("C write_error", 32'(werr), 32'd0);

      // Short sector: error flagged, sector retired, address advances.
      do_reset();
      load_base(32'd300);
      stream(512, 5, 1'b0);
      serve(32'd300, 300, 1'b1);
      chk("D write_error short", 32'(werr), 32'd1);
      chk("D sectors_written", scnt, 32'd1);
      stream(512, 9, 1'b0);
      serve(32'd301, 512, 1'b1);
      chk("D sectors_written 2", scnt, 32'd2);
      chk("D write_error sticky", 32'(werr), 32'd1);

      // Reset during SEND after 200 bytes: no retry afterwards.
      do_reset();
      load_base(32'd55);
      stream(512, 0, 1'b0);
      serve(32'd55, 200, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("E StartWrite", 32'(sw), 32'd0);
      chk("E sectors_written", scnt, 32'd0);
      chk("E in_ready", 32'(in_ready), 32'd1);
      chk("E feeder_busy", 32'(busy), 32'd0);
      chk("E inByte", 32'(inbyte), 32'd0);
      chk("E writeSectorAddress", wsa, 32'd0);
      rst = 1'b0; ial = 1'b1; exp_q.delete();
      repeat (20) @(negedge clk);
      chk("E no retry StartWrite", 32'(sw), 32'd0);
      chk("E no retry busy", 32'(busy), 32'd0);

      // Timeout on the 1000-cycle instance; main instance held in reset.
      rst = 1'b1;
      rst_t = 1'b0;
      @(negedge clk);
      load_base(32'd77);
      stream(512, 0, 1'b1);
      begin
         int guard;
         guard = 0;
         while (t_sw !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 100) begin
            total++; bad++;
            $display("FAIL timeout StartWrite wait: StartWrite stayed 0, expected 1");
         end else begin
            chk("F address", t_wsa, 32'd77);
            repeat (998) @(negedge clk);
            chk("F write_error before timeout", 32'(t_werr), 32'd0);
            @(negedge clk);
            chk("F write_error at timeout", 32'(t_werr), 32'd1);
            chk("F StartWrite dropped", 32'(t_sw), 32'd0);
            @(negedge clk);
            chk("F StartWrite reasserted", 32'(t_sw), 32'd1);
            chk("F same address", t_wsa, 32'd77);
            chk("F sectors_written", t_scnt, 32'd0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
